// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-ported RAM between an instruction cache (line fills only)
// and a data cache (line fills and writebacks). One transaction is in flight
// at a time. The controller steps through three states:
//   IDLE : pick a requester and accept it (ready is combinational)
//   MEM  : present the latched request to the RAM until mem_ready
//   RESP : pulse the owner's resp_valid for one cycle
// When both caches ask in the same IDLE cycle, the one that was not served
// last wins. After reset the icache counts as served last, so the dcache
// wins the first tie.
//
// Ports
//   clk, RESET                      clock, asynchronous active-low reset
//   ic_req_valid/addr/ready         icache fill request handshake
//   ic_resp_valid/data              icache completion pulse and fill line
//   dc_req_valid/rw/addr/data/ready dcache request handshake (rw=1 writeback)
//   dc_resp_valid/data              dcache completion pulse and fill line
//   mem_valid/rw/addr/wdata         RAM request (rw=1 write)
//   mem_ready/rdata                 RAM completion pulse and read line
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              RESET,

    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,

    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_data,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data,

    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    state_e            state_q,    state_d;
    owner_e            owner_q,    owner_d;
    owner_e            last_q,     last_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              rw_q,       rw_d;
    logic [LINE_W-1:0] wdata_q,    wdata_d;
    logic [LINE_W-1:0] ic_data_q,  ic_data_d;
    logic [LINE_W-1:0] dc_data_q,  dc_data_d;

    logic grant_ic;
    logic grant_dc;
    logic accept_ic;
    logic accept_dc;

    // Round-robin pick: a lone requester always wins; on a tie the requester
    // that was not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (ic_req_valid && dc_req_valid) begin
            if (last_q == OWN_IC) grant_dc = 1'b1;
            else                  grant_ic = 1'b1;
        end else begin
            grant_ic = ic_req_valid;
            grant_dc = dc_req_valid;
        end
    end

    // Readies are also gated by the reset pin itself so they drop the moment
    // reset asserts, not at the next clock edge.
    assign accept_ic = (state_q == ST_IDLE) && RESET && grant_ic;
    assign accept_dc = (state_q == ST_IDLE) && RESET && grant_dc;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        ic_data_d = ic_data_q;
        dc_data_d = dc_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_ic) begin
                    addr_d  = ic_req_addr;
                    rw_d    = 1'b0;           // icache only ever reads
                    wdata_d = '0;
                    owner_d = OWN_IC;
                    state_d = ST_MEM;
                end else if (accept_dc) begin
                    addr_d  = dc_req_addr;
                    rw_d    = dc_req_rw;
                    wdata_d = dc_req_data;
                    owner_d = OWN_DC;
                    state_d = ST_MEM;
                end
            end

            ST_MEM: begin
                // A write completes with an all-zero response line.
                if (mem_ready) begin
                    if (owner_q == OWN_IC) ic_data_d = rw_q ? '0 : mem_rdata;
                    else                   dc_data_d = rw_q ? '0 : mem_rdata;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IC;
            last_q    <= OWN_IC;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            ic_data_q <= '0;
            dc_data_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples its _d value from before this clock edge.
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            ic_data_q <= ic_data_d;
            dc_data_q <= dc_data_d;
        end
    end

    assign ic_req_ready  = accept_ic;
    assign dc_req_ready  = accept_dc;

    assign mem_valid     = (state_q == ST_MEM);
    assign mem_rw        = rw_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

    assign ic_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IC);
    assign dc_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_DC);
    assign ic_resp_data  = ic_data_q;
    assign dc_resp_data  = dc_data_q;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache-line width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ic_req_valid  input  1  icache line-fill request (read only).
REQ-006 SHALL have port ic_req_addr  input  ADDR_W  icache line address.
REQ-007 SHALL have port ic_req_ready  output  1  icache request accepted this cycle.
REQ-008 SHALL have port ic_resp_valid  output  1  one-cycle icache fill-complete pulse.
REQ-009 SHALL have port ic_resp_data  output  LINE_W  icache fill data.
REQ-010 SHALL have port dc_req_valid  input  1  dcache request (fill or writeback).
REQ-011 SHALL have port dc_req_rw  input  1  1 = writeback, 0 = fill.
REQ-012 SHALL have port dc_req_addr  input  ADDR_W  dcache line address.
REQ-013 SHALL have port dc_req_data  input  LINE_W  dcache writeback line.
REQ-014 SHALL have port dc_req_ready  output  1  dcache request accepted this cycle.
REQ-015 SHALL have port dc_resp_valid  output  1  one-cycle dcache completion pulse.
REQ-016 SHALL have port dc_resp_data  output  LINE_W  dcache fill data.
REQ-017 SHALL have ports mem_valid, mem_rw  output  1 each  RAM request valid and direction (1 = write).
REQ-018 SHALL have ports mem_addr and mem_wdata  output  ADDR_W and LINE_W  RAM address and write line.
REQ-019 SHALL have ports mem_ready and mem_rdata  input  1 and LINE_W  RAM completion pulse and read line.

Function
REQ-020 SHALL implement FSM states IDLE, MEM, RESP, and an owner register (IC or DC).
REQ-021 In IDLE, *_req_ready SHALL be combinational: high only for the requester selected this cycle; at most one ready high.
REQ-022 Selection in IDLE: a single valid requester wins; with both valid, the requester not served last wins (round-robin).
REQ-023 On accept, SHALL latch addr, rw (icache forced 0), wdata, and owner; next state MEM.
REQ-024 In MEM, mem_valid=1 with latched addr/rw/wdata held stable until mem_ready; no ready outputs high.
REQ-025 On mem_ready in MEM, SHALL register mem_rdata (reads) or zero (writes) into the owner's resp_data; next state RESP.
REQ-026 In RESP, the owner's resp_valid=1 for exactly one cycle, mem_valid=0; next state IDLE; last-served := owner.
REQ-027 resp_data SHALL hold its value until the next completion for that requester.
REQ-028 Minimum latency: accept at cycle N, mem_valid at N+1; with mem_ready at N+1, resp_valid at N+2; next accept at N+3.
REQ-029 mem_ready in IDLE or RESP SHALL be ignored.
REQ-030 Requesters hold *_req_valid until ready; deassertion before ready SHALL cancel the request without side effects.
REQ-031 A request arriving while not in IDLE SHALL wait; no requester starves beyond one other transaction.

Reset
REQ-032 RESET low SHALL immediately force state IDLE, last-served := IC (so DC wins the first tie), all valid/ready outputs 0, mem_addr, mem_wdata, resp_data 0, mem_rw 0.
REQ-033 Reset mid-transaction SHALL abandon it: no resp_valid, mem_valid drops asynchronously.

Verification
REQ-034 Lone icache fill addr 0x0000_1000, mem_ready one cycle after mem_valid with rdata 0xA5..A5 -> mem_rw=0, ic_resp_valid one pulse with 0xA5..A5 at N+2.
REQ-035 Both request in same IDLE cycle after reset -> dc granted first, ic granted at the IDLE following dc_resp_valid.
REQ-036 Dcache writeback addr 0x0000_2040, data 0x1234..; mem_ready delayed 5 cycles -> mem_valid/mem_rw=1/addr/wdata stable for 5 cycles, dc_resp_valid pulse, dc_resp_data=0.
REQ-037 Both requesters continuously valid for 6 transactions -> grants alternate DC, IC, DC, IC, DC, IC.
REQ-038 RESET low during MEM -> mem_valid 0 immediately, no resp_valid, next transaction after release completes normally.
REQ-039 mem_ready pulsed while IDLE -> no state change, no resp_valid.
